// File: rtl/bus_interconnect.sv
// Single-master to NUM_SLAVES address-decoded interconnect with per-access
// timeout, registered response path and a sticky error address/counter.
module bus_interconnect #(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
        {32'hF1000000, 32'hF0000000, 32'h00010000, 32'h00000000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK =
        {32'hFFFFFFF8, 32'hFFFFFFF8, 32'hFFFF0000, 32'hFFFF0000},
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         m_req,
    input  logic                         m_we,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_wdata,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_ack,
    output logic                         m_err,
    output logic [NUM_SLAVES-1:0]        s_cs,
    output logic                         s_we,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]        s_ack,
    output logic [ADDR_W-1:0]            err_addr,
    output logic [15:0]                  err_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [DATA_W-1:0]       m_rdata_q, m_rdata_d;
    logic                    m_ack_q, m_ack_d;
    logic                    m_err_q, m_err_d;
    logic [NUM_SLAVES-1:0]   s_cs_q, s_cs_d;
    logic                    s_we_q, s_we_d;
    logic [ADDR_W-1:0]       s_addr_q, s_addr_d;
    logic [DATA_W-1:0]       s_wdata_q, s_wdata_d;
    logic [ADDR_W-1:0]       err_addr_q, err_addr_d;
    logic [15:0]             err_count_q, err_count_d;
    logic [7:0]              tmo_cnt_q, tmo_cnt_d;

    logic [NUM_SLAVES-1:0]   match_s;
    logic [NUM_SLAVES-1:0]   hit_oh_s;
    logic                    sel_ack_s;
    logic [DATA_W-1:0]       sel_rdata_s;
    logic [15:0]             err_count_inc_s;

    // Address decode; x & -x isolates the lowest set bit so the lowest index wins.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            match_s[i] = ((m_addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) ==
                          (SLAVE_BASE[i*ADDR_W +: ADDR_W] & SLAVE_MASK[i*ADDR_W +: ADDR_W]));
        end
        hit_oh_s = match_s & (-match_s);
    end

    // Only the selected slave's ack and read data are visible to the FSM.
    always_comb begin
        sel_ack_s   = |(s_ack & s_cs_q);
        sel_rdata_s = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            sel_rdata_s = sel_rdata_s | (s_rdata[i*DATA_W +: DATA_W] & {DATA_W{s_cs_q[i]}});
        end
        err_count_inc_s = (err_count_q == 16'hFFFF) ? err_count_q : (err_count_q + 16'd1);
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        m_rdata_d   = m_rdata_q;
        m_ack_d     = 1'b0;
        m_err_d     = 1'b0;
        s_cs_d      = s_cs_q;
        s_we_d      = s_we_q;
        s_addr_d    = s_addr_q;
        s_wdata_d   = s_wdata_q;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        tmo_cnt_d   = tmo_cnt_q;
        case (state_q)
            IDLE: begin
                s_cs_d = '0;
                s_we_d = 1'b0;
                if (m_req && (|match_s)) begin
                    s_cs_d    = hit_oh_s;
                    s_we_d    = m_we;
                    s_addr_d  = m_addr;
                    s_wdata_d = m_wdata;
                    tmo_cnt_d = 8'd0;
                    state_d   = ACCESS;
                end else if (m_req) begin
                    err_addr_d  = m_addr;
                    err_count_d = err_count_inc_s;
                    m_rdata_d   = '0;
                    m_ack_d     = 1'b1;
                    m_err_d     = 1'b1;
                    state_d     = RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                // An ack on the last allowed cycle still counts as success.
                if (sel_ack_s) begin
                    if (!s_we_q) begin
                        m_rdata_d = sel_rdata_s;
                    end else begin
                        m_rdata_d = m_rdata_q;
                    end
                    m_ack_d = 1'b1;
                    s_cs_d  = '0;
                    s_we_d  = 1'b0;
                    state_d = RESP;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    err_addr_d  = s_addr_q;
                    err_count_d = err_count_inc_s;
                    m_rdata_d   = '0;
                    m_ack_d     = 1'b1;
                    m_err_d     = 1'b1;
                    s_cs_d      = '0;
                    s_we_d      = 1'b0;
                    state_d     = RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            RESP: begin
                s_cs_d  = '0;
                s_we_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                s_cs_d  = '0;
                s_we_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            m_rdata_q   <= '0;
            m_ack_q     <= 1'b0;
            m_err_q     <= 1'b0;
            s_cs_q      <= '0;
            s_we_q      <= 1'b0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            err_addr_q  <= '0;
            err_count_q <= 16'd0;
            tmo_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            m_rdata_q   <= m_rdata_d;
            m_ack_q     <= m_ack_d;
            m_err_q     <= m_err_d;
            s_cs_q      <= s_cs_d;
            s_we_q      <= s_we_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign m_rdata   = m_rdata_q;
    assign m_ack     = m_ack_q;
    assign m_err     = m_err_q;
    assign s_cs      = s_cs_q;
    assign s_we      = s_we_q;
    assign s_addr    = s_addr_q;
    assign s_wdata   = s_wdata_q;
    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_bus_interconnect.sv
// Scoreboard bench for bus_interconnect (default map, TIMEOUT=4).
module tb_bus_interconnect;

    logic          clk = 1'b0;
    logic          reset;
    logic          m_req;
    logic          m_we;
    logic [31:0]   m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata;
    logic          m_ack;
    logic          m_err;
    logic [3:0]    s_cs;
    logic          s_we;
    logic [31:0]   s_addr;
    logic [31:0]   s_wdata;
    logic [127:0]  s_rdata;
    logic [3:0]    s_ack;
    logic [31:0]   err_addr;
    logic [15:0]   err_count;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          cs_cycles;
        logic [3:0]  cs;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] model_rdata = 32'h0;
    logic [15:0] model_errs  = 16'h0;

    // observation results of the most recent transaction
    int          o_cs_cycles, o_ack_cycle;
    logic [3:0]  o_cs;
    logic        o_cs_stable, o_we_ok, o_got_ack, o_err, o_pulse_ok;
    logic [31:0] o_wdata, o_addr, o_rdata;

    bus_interconnect #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
        .s_cs(s_cs), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ack(s_ack), .err_addr(err_addr), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Drives one request and plays the slave; ack_after<0 means never ack.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input int ack_after, input int ack_slave, input logic [31:0] sdata,
                           input logic [3:0] noise);
        o_cs_cycles = 0; o_cs = 4'h0; o_cs_stable = 1'b1; o_we_ok = 1'b1;
        o_wdata = 32'h0; o_addr = 32'h0; o_got_ack = 1'b0; o_rdata = 32'h0;
        o_err = 1'b0; o_ack_cycle = -1; o_pulse_ok = 1'b0;
        @(negedge clk);
        m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata; s_ack = noise;
        for (int i = 0; i < 4; i++) s_rdata[i*32 +: 32] = 32'hA0000000 + 32'(i);
        s_rdata[ack_slave*32 +: 32] = sdata;
        @(posedge clk);
        @(negedge clk);
        m_req = 1'b0; m_we = ~we; m_addr = 32'h0000_0000; m_wdata = 32'h5555_5555;
        for (int cyc = 1; cyc <= 20 && !o_got_ack; cyc++) begin
            if (s_cs !== 4'h0) begin
                if (o_cs_cycles == 0) begin
                    o_cs = s_cs; o_wdata = s_wdata; o_addr = s_addr;
                end else if (s_cs !== o_cs) begin
                    o_cs_stable = 1'b0;
                end else begin
                    o_cs_stable = o_cs_stable;
                end
                if (s_we !== we) o_we_ok = 1'b0;
                s_ack = ((ack_after >= 0 && o_cs_cycles == ack_after) ?
                         (4'b0001 << ack_slave) : 4'b0000) | noise;
                o_cs_cycles++;
            end else begin
                if (s_we !== 1'b0) o_we_ok = 1'b0;
                s_ack = noise;
            end
            if (m_ack === 1'b1) begin
                o_got_ack = 1'b1; o_rdata = m_rdata; o_err = m_err; o_ack_cycle = cyc;
            end
            @(negedge clk);
        end
        s_ack = 4'h0;
        o_pulse_ok = (m_ack === 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0;
        s_rdata = '0; s_ack = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if ({m_ack, m_err, s_we} !== 3'b000) begin n_fail++;
            $display("FAIL reset_flags got %b want 000", {m_ack, m_err, s_we}); end
        n_checks++; if (s_cs !== 4'h0) begin n_fail++;
            $display("FAIL reset_s_cs got %h want 0", s_cs); end
        n_checks++; if ({m_rdata, s_addr, s_wdata, err_addr} !== 128'h0) begin n_fail++;
            $display("FAIL reset_data got %h %h %h %h want 0", m_rdata, s_addr, s_wdata, err_addr); end
        n_checks++; if (err_count !== 16'h0) begin n_fail++;
            $display("FAIL reset_err_count got %h want 0", err_count); end
        reset = 1'b0;
    endtask

    // Compares the transaction just run against the oldest scoreboard entry.
    task automatic check_common(input string name);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL %s scoreboard empty", name); return; end
        e = sb.pop_front();
        if (o_got_ack !== 1'b1) begin n_fail++;
            $display("FAIL %s no m_ack within bound", name); return; end
        n_checks++; if (o_rdata !== e.rdata) begin n_fail++;
            $display("FAIL %s m_rdata got %h want %h", name, o_rdata, e.rdata); end
        n_checks++; if (o_err !== e.err) begin n_fail++;
            $display("FAIL %s m_err got %b want %b", name, o_err, e.err); end
        n_checks++; if (o_ack_cycle != e.lat) begin n_fail++;
            $display("FAIL %s ack_cycle got %0d want %0d", name, o_ack_cycle, e.lat); end
        n_checks++; if (o_cs_cycles != e.cs_cycles || o_cs !== e.cs || !o_cs_stable) begin n_fail++;
            $display("FAIL %s s_cs got %h x%0d stable=%b want %h x%0d", name, o_cs, o_cs_cycles,
                     o_cs_stable, e.cs, e.cs_cycles); end
        n_checks++; if (!o_pulse_ok || !o_we_ok) begin n_fail++;
            $display("FAIL %s pulse/we got %b%b want 11", name, o_pulse_ok, o_we_ok); end
    endtask

    task automatic test_read_hit();
        model_rdata = 32'hDEADBEEF;
        sb.push_back('{model_rdata, 1'b0, 2, 1, 4'b0010});
        run_txn(32'h00010004, 1'b0, 32'h0, 0, 1, 32'hDEADBEEF, 4'h0);
        check_common("read_hit");
        n_checks++; if (o_addr !== 32'h00010004) begin n_fail++;
            $display("FAIL read_hit s_addr got %h want 00010004", o_addr); end
    endtask

    task automatic test_write_hit();
        sb.push_back('{model_rdata, 1'b0, 4, 3, 4'b0100});
        run_txn(32'hF0000004, 1'b1, 32'h0000003F, 2, 2, 32'h12345678, 4'h0);
        check_common("write_hit");
        n_checks++; if (o_wdata !== 32'h3F) begin n_fail++;
            $display("FAIL write_hit s_wdata got %h want 0000003f", o_wdata); end
    endtask

    task automatic test_miss();
        model_errs++;
        sb.push_back('{32'h0, 1'b1, 1, 0, 4'b0000});
        run_txn(32'h05E00000, 1'b0, 32'h0, 0, 0, 32'h0, 4'h0);
        check_common("miss");
        n_checks++; if (err_addr !== 32'h05E00000 || err_count !== model_errs) begin n_fail++;
            $display("FAIL miss err got %h/%h want 05e00000/%h", err_addr, err_count, model_errs); end
    endtask

    task automatic test_timeout();
        model_errs++;
        sb.push_back('{32'h0, 1'b1, 5, 4, 4'b1000});
        run_txn(32'hF1000000, 1'b0, 32'h0, -1, 3, 32'h0BADF00D, 4'b0001);
        check_common("timeout");
        n_checks++; if (err_addr !== 32'hF1000000 || err_count !== model_errs) begin n_fail++;
            $display("FAIL timeout err got %h/%h want f1000000/%h", err_addr, err_count, model_errs); end
        model_rdata = 32'hCAFEF00D;
        sb.push_back('{model_rdata, 1'b0, 5, 4, 4'b1000});
        run_txn(32'hF1000000, 1'b0, 32'h0, 3, 3, 32'hCAFEF00D, 4'h0);
        check_common("ack_last_cycle");
        n_checks++; if (err_count !== model_errs) begin n_fail++;
            $display("FAIL ack_last_cycle err_count got %h want %h", err_count, model_errs); end
    endtask

    task automatic test_reset_in_access();
        logic seen_ack;
        seen_ack = 1'b0;
        @(negedge clk);
        m_req = 1'b1; m_we = 1'b0; m_addr = 32'h00000000;
        @(negedge clk);
        m_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen_ack = m_ack;
        n_checks++; if ({s_cs, s_we, m_ack, m_err} !== 7'h0 || m_rdata !== 32'h0 || err_count !== 16'h0)
            begin n_fail++;
            $display("FAIL reset_in_access got cs=%h we=%b ack=%b err=%b rd=%h ec=%h want 0",
                     s_cs, s_we, m_ack, m_err, m_rdata, err_count); end
        repeat (3) begin @(negedge clk); seen_ack = seen_ack | m_ack; end
        n_checks++; if (seen_ack !== 1'b0) begin n_fail++;
            $display("FAIL reset_in_access_no_ack got %b want 0", seen_ack); end
        model_errs = 16'h0;
        model_rdata = 32'h00C0FFEE;
        sb.push_back('{model_rdata, 1'b0, 2, 1, 4'b0001});
        run_txn(32'h00000000, 1'b0, 32'h0, 0, 0, 32'h00C0FFEE, 4'h0);
        check_common("after_reset_read");
    endtask

    task automatic test_saturation();
        @(negedge clk);
        force dut.err_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.err_count_q;
        model_errs = 16'hFFFE;
        for (int k = 0; k < 2; k++) begin
            model_errs = (model_errs == 16'hFFFF) ? model_errs : model_errs + 16'd1;
            sb.push_back('{32'h0, 1'b1, 1, 0, 4'b0000});
            run_txn(32'h12345678, 1'b0, 32'h0, 0, 0, 32'h0, 4'h0);
            check_common("sat_miss");
            n_checks++; if (err_count !== model_errs) begin n_fail++;
                $display("FAIL saturation err_count got %h want %h", err_count, model_errs); end
        end
        n_checks++; if (err_addr !== 32'h12345678) begin n_fail++;
            $display("FAIL saturation err_addr got %h want 12345678", err_addr); end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_write_hit();
        test_miss();
        test_timeout();
        test_reset_in_access();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_interconnect.md
BUS_INTERCONNECT -- requirements
Module: bus_interconnect

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of slave regions (1..16).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width.
REQ-004 SHALL have parameter SLAVE_BASE, default {32'hF1000000, 32'hF0000000, 32'h00010000, 32'h00000000}, packed NUM_SLAVES*ADDR_W base addresses; slave i occupies slice i.
REQ-005 SHALL have parameter SLAVE_MASK, default {32'hFFFFFFF8, 32'hFFFFFFF8, 32'hFFFF0000, 32'hFFFF0000}, packed compare masks, same slicing.
REQ-006 SHALL have parameter TIMEOUT, default 15, maximum slave-select cycles before a forced error (2..255).
REQ-007 SHALL have ports, in order:
 clk  in  1  clock, all logic on rising edge.
 reset  in  1  synchronous, active-high.
 m_req  in  1  master access request.
 m_we  in  1  1 = write, 0 = read.
 m_addr  in  ADDR_W  master address.
 m_wdata  in  DATA_W  master write data.
 m_rdata  out  DATA_W  registered read data.
 m_ack  out  1  one-cycle completion pulse.
 m_err  out  1  one-cycle error flag, valid with m_ack.
 s_cs  out  NUM_SLAVES  one-hot slave select.
 s_we  out  1  slave write strobe.
 s_addr  out  ADDR_W  latched address to slaves.
 s_wdata  out  DATA_W  latched write data to slaves.
 s_rdata  in  NUM_SLAVES*DATA_W  packed slave read data.
 s_ack  in  NUM_SLAVES  per-slave completion.
 err_addr  out  ADDR_W  address of most recent failed access.
 err_count  out  16  saturating failed-access count.
REQ-008 Clock SHALL be named clk; reset SHALL be named reset, synchronous and active-high.

Function
REQ-009 Slave i SHALL hit when (m_addr & MASK[i]) == (BASE[i] & MASK[i]); on multiple hits the lowest index SHALL win.
REQ-010 FSM SHALL have states IDLE, ACCESS, RESP.
REQ-011 IDLE, m_req=1, hit: SHALL latch m_addr/m_wdata/m_we into s_addr/s_wdata/s_we path, assert s_cs[i], clear timeout counter, go ACCESS.
REQ-012 IDLE, m_req=1, miss: SHALL capture err_addr=m_addr, increment err_count, set m_rdata=0, go RESP with m_err=1.
REQ-013 ACCESS: s_cs, s_addr, s_wdata SHALL hold stable; s_we SHALL equal latched m_we; only s_ack of the selected slave SHALL be observed.
REQ-014 ACCESS, selected s_ack=1: read SHALL load m_rdata from that slave's s_rdata slice; write SHALL leave m_rdata unchanged; go RESP with m_err=0.
REQ-015 ACCESS, no ack, counter = TIMEOUT-1: SHALL go RESP with m_err=1, m_rdata=0, capture err_addr=s_addr, increment err_count; otherwise counter SHALL increment.
REQ-016 Ack on the final timeout cycle SHALL take precedence over timeout (success).
REQ-017 RESP: m_ack=1 for exactly one cycle, s_cs=0, s_we=0, then IDLE; m_req is ignored in ACCESS and RESP.
REQ-018 Minimum latency: req sampled edge 0, s_cs high cycle 1, ack sampled edge 1, m_ack high cycle 2; miss gives m_ack in cycle 1.
REQ-019 err_count SHALL saturate at 16'hFFFF; err_addr SHALL hold until next error.
REQ-020 s_we SHALL be 0 whenever s_cs is all-zero.

Reset
REQ-021 On reset: state IDLE; m_rdata, m_ack, m_err, s_cs, s_we, s_addr, s_wdata, err_addr, err_count, timeout counter all 0.
REQ-022 Reset during ACCESS SHALL drop s_cs at that edge and produce no m_ack.

Verification (default parameters, TIMEOUT=4)
REQ-023 Read 0x00010004, slave 1 acks first cycle with 0xDEADBEEF -> s_cs=4'b0010 one cycle, m_ack cycle 2, m_rdata=0xDEADBEEF, m_err=0.
REQ-024 Write 0xF0000004 data 0x3F, slave 2 acks after 2 cycles -> s_cs=4'b0100 and s_we=1 for 3 cycles, s_wdata=0x3F, m_ack m_err=0, m_rdata unchanged.
REQ-025 Read 0x05E00000 (unmapped) -> s_cs stays 0, m_ack=1 m_err=1 cycle 1, m_rdata=0, err_addr=0x05E00000, err_count=1.
REQ-026 Read 0xF1000000, slave 3 never acks -> s_cs=4'b1000 exactly 4 cycles, then m_ack=m_err=1, err_count increments; repeat with ack on 4th cycle -> success, no error.
REQ-027 Assert reset in second ACCESS cycle -> next cycle all outputs 0, no m_ack; following read to 0x00000000 completes normally.
REQ-028 Preload err_count=0xFFFE via two-step forcing or 65534 misses, two further misses -> err_count=0xFFFF, not wrapped.
